// File: rtl/freemachine_sched_if.sv
// Shared memory-bank port between the freemachine scheduler (master) and the bank (slave).
interface freemachine_sched_if #(
  parameter int unsigned BANK_ADDR_WIDTH = 8,
  parameter int unsigned COL_ADDR_WIDTH  = 6,
  parameter int unsigned TX_DATA_WIDTH   = 32
);
  logic                       mem_req;
  logic                       mem_we;
  logic [BANK_ADDR_WIDTH-1:0] mem_row;
  logic [COL_ADDR_WIDTH-1:0]  mem_col;
  logic [TX_DATA_WIDTH-1:0]   mem_wdata;
  logic                       mem_ack;
  logic [TX_DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_row, mem_col, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_row, mem_col, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/freemachine_sched.sv
// Prune-job scheduler: launches freemachine workers pass by pass until nothing changes, and
// arbitrates their accesses to a single memory bank port (writers first, round-robin).
module freemachine_sched #(
  parameter int unsigned N_WORKERS       = 4,
  parameter int unsigned MAX_PASSES      = 255,
  parameter int unsigned BANK_ADDR_WIDTH = 8,
  parameter int unsigned COL_ADDR_WIDTH  = 6,
  parameter int unsigned TX_DATA_WIDTH   = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [N_WORKERS-1:0]                 wk_read_en,
  input  logic [N_WORKERS-1:0]                 wk_write_en,
  input  logic [N_WORKERS*BANK_ADDR_WIDTH-1:0] wk_row_addr,
  input  logic [N_WORKERS*COL_ADDR_WIDTH-1:0]  wk_col_addr,
  input  logic [N_WORKERS*TX_DATA_WIDTH-1:0]   wk_wdata,
  input  logic [N_WORKERS-1:0]                 wk_changed,
  input  logic [N_WORKERS-1:0]                 wk_done,
  output logic [N_WORKERS-1:0]                 wk_run,
  output logic [N_WORKERS-1:0]                 wk_ack,
  output logic [TX_DATA_WIDTH-1:0]             wk_rdata,
  freemachine_sched_if.master                  mem,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 abort,
  output logic [7:0]                           pass_count
);

  localparam int unsigned IdxW = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StCheck, StFinish} state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 pass_q, pass_d, pass_next;
  logic                       abort_q, abort_d;
  logic                       changed_q, changed_d;
  idx_t                       ptr_q, ptr_d;
  idx_t                       gnt_idx_q, gnt_idx_d;
  logic                       gnt_vld_q, gnt_vld_d;
  logic                       gnt_we_q, gnt_we_d;
  logic [BANK_ADDR_WIDTH-1:0] row_q, row_d;
  logic [COL_ADDR_WIDTH-1:0]  col_q, col_d;
  logic [TX_DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                 ack_ok, all_done, in_run;
  logic [N_WORKERS-1:0] wr_elig, any_elig, cls;
  logic                 pick_found;
  idx_t                 pick_idx, cand;

  // An ack with no outstanding grant is stray and must not release anything.
  assign ack_ok   = mem.mem_ack & gnt_vld_q;
  assign all_done = &wk_done;
  assign in_run   = (state_q == StRun);

  always_comb begin : p_arb
    wr_elig    = in_run ? wk_write_en : '0;
    any_elig   = in_run ? (wk_read_en | wk_write_en) : '0;
    cls        = (|wr_elig) ? wr_elig : any_elig;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_WORKERS; k++) begin
      cand = idx_t'((32'(ptr_q) + k) % N_WORKERS);
      if (!pick_found && cls[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin : p_next
    state_d   = state_q;
    pass_d    = pass_q;
    abort_d   = abort_q;
    changed_d = changed_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    gnt_we_d  = gnt_we_q;
    row_d     = row_q;
    col_d     = col_q;
    wdata_d   = wdata_q;
    pass_next = pass_q + 8'd1;

    case (state_q)
      StIdle, StFinish: begin
        if (start) begin
          state_d   = StLaunch;
          pass_d    = '0;
          abort_d   = 1'b0;
          changed_d = 1'b0;
        end
      end
      StLaunch: begin
        changed_d = 1'b0;
        state_d   = StRun;
      end
      StRun: begin
        changed_d = changed_q | (|wk_changed);
        if (all_done && !gnt_vld_q) state_d = StCheck;
      end
      StCheck: begin
        pass_d = pass_next;
        if (!changed_q) begin
          state_d = StFinish;
        end else if (pass_next == 8'(MAX_PASSES)) begin
          state_d = StFinish;
          abort_d = 1'b1;
        end else begin
          state_d = StLaunch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Fields are captured at grant time so the bank sees them stable until ack.
    if (ack_ok) begin
      gnt_vld_d = 1'b0;
      ptr_d     = (gnt_idx_q == idx_t'(N_WORKERS - 1)) ? '0 : gnt_idx_q + 1'b1;
    end else if (!gnt_vld_q && pick_found && !all_done) begin
      gnt_vld_d = 1'b1;
      gnt_idx_d = pick_idx;
      gnt_we_d  = wk_write_en[pick_idx];
      row_d     = wk_row_addr[pick_idx*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
      col_d     = wk_col_addr[pick_idx*COL_ADDR_WIDTH +: COL_ADDR_WIDTH];
      wdata_d   = wk_wdata[pick_idx*TX_DATA_WIDTH +: TX_DATA_WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pass_q    <= '0;
      abort_q   <= 1'b0;
      changed_q <= 1'b0;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      gnt_we_q  <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      abort_q   <= abort_d;
      changed_q <= changed_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_we_q  <= gnt_we_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin : p_ack
    wk_ack = '0;
    if (ack_ok) wk_ack[gnt_idx_q] = 1'b1;
  end

  assign mem.mem_req   = gnt_vld_q;
  assign mem.mem_we    = gnt_vld_q & gnt_we_q;
  assign mem.mem_row   = row_q;
  assign mem.mem_col   = col_q;
  assign mem.mem_wdata = wdata_q;

  assign wk_rdata   = mem.mem_rdata;
  assign wk_run     = {N_WORKERS{state_q == StLaunch}};
  assign busy       = (state_q == StLaunch) || (state_q == StRun) || (state_q == StCheck);
  assign done       = (state_q == StFinish);
  assign abort      = abort_q;
  assign pass_count = pass_q;

endmodule
